store_buffer: RTL and testbench

- Write side of the data-SRAM interface. Committed stores from the MEM stage are queued in a small FIFO and drained to data_sram in order.
- Younger loads look up the queue and receive byte-granular forwarded data, merged youngest-first.
- A load that only partially overlaps a buffered store raises a stall request. The hazard unit ORs this stall with the existing load-use stall.

---
 rtl/store_buffer_pkg.sv | 17 +
 rtl/sb_lane_select.sv | 30 +++
 rtl/store_buffer.sv | 166 ++++++++++++++++
 tb/tb_store_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the data-SRAM store buffer.
// Entry field widths are fixed by the 32-bit word-addressed data SRAM.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_PTR_W  = 2;
    localparam int SB_WORD_W = 30;
    localparam int SB_WEN_W  = 4;
    localparam int SB_DATA_W = 32;

    // Stall requests handed to the hazard unit.
    typedef struct packed {
        logic store;
        logic ld_conflict;
    } stall_bus_t;

endpackage

// File: rtl/sb_lane_select.sv
// Per-byte-lane forwarding selector: picks the youngest buffered entry that
// supplies this lane for the load's word.
module sb_lane_select #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic [DEPTH-1:0]      hit,
    input  logic [DEPTH-1:0][7:0] lane_bytes,
    input  logic [PTR_W-1:0]      head,
    output logic                  found,
    output logic [7:0]            sel
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest starting at head; the last match is the youngest.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (hit[idx]) begin
                found = 1'b1;
                sel   = lane_bytes[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data_sram: in-order drain, youngest-entry
// coalescing, and byte-granular load forwarding with a partial-overlap stall.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = SB_PTR_W
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_wen,
    input  logic [31:0] st_wdata,
    output logic        st_ready,
    output logic        stallreq_for_store,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_ben,
    output logic        ld_fwd_hit,
    output logic [31:0] ld_fwd_data,
    output logic [3:0]  ld_fwd_mask,
    output logic        stallreq_for_ld_conflict,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_ready,
    output logic        sb_empty
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);

    logic [DEPTH-1:0]           valid;
    logic [SB_WORD_W-1:0]       word_q [DEPTH];
    logic [SB_WEN_W-1:0]        wen_q  [DEPTH];
    logic [SB_DATA_W-1:0]       data_q [DEPTH];
    logic [PTR_W-1:0]           head;
    logic [PTR_W-1:0]           tail;
    logic [PTR_W:0]             count;

    logic [SB_WORD_W-1:0]       st_word;
    logic [SB_WORD_W-1:0]       ld_word;
    logic [PTR_W-1:0]           youngest;
    logic                       head_vld;
    logic                       retire;
    logic                       merge;
    logic                       alloc;
    logic [PTR_W:0]             count_nxt;
    logic [DEPTH-1:0]           word_match;
    logic [3:0]                 lane_found;
    logic [3:0][7:0]            lane_byte;
    stall_bus_t                 stall;
    logic                       unused_addr_bits;

    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_word  = st_addr[31:2];
    assign ld_word  = ld_addr[31:2];
    assign youngest = tail - 1'b1;
    assign head_vld = (count != '0);
    assign retire   = head_vld & data_sram_ready;

    // With a single entry the youngest is the head, which may be mid-handshake,
    // so coalescing needs at least two entries.
    assign merge    = st_valid & (count >= CNT_TWO) & (word_q[youngest] == st_word);
    assign st_ready = merge | (count != CNT_FULL) | retire;
    assign alloc    = st_valid & ~merge & st_ready;

    always_comb begin
        count_nxt = count;
        if (alloc && !retire) begin
            count_nxt = count + 1'b1;
        end else if (!alloc && retire) begin
            count_nxt = count - 1'b1;
        end
    end

    // Control state: the only reset flops.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (retire) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            // Ordered after retire so a full-buffer alloc into the retiring slot wins.
            if (alloc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            count <= count_nxt;
        end
    end

    // Entry payload: only meaningful under valid, so never reset.
    always_ff @(posedge clk) begin
        if (merge) begin
            for (int b = 0; b < 4; b++) begin
                if (st_wen[b]) begin
                    data_q[youngest][8*b +: 8] <= st_wdata[8*b +: 8];
                end
            end
            wen_q[youngest] <= wen_q[youngest] | st_wen;
        end else if (alloc) begin
            word_q[tail] <= st_word;
            wen_q[tail]  <= st_wen;
            data_q[tail] <= st_wdata;
        end
    end

    assign data_sram_en    = head_vld;
    assign data_sram_wen   = head_vld ? wen_q[head] : '0;
    assign data_sram_addr  = head_vld ? {word_q[head], 2'b00} : '0;
    assign data_sram_wdata = head_vld ? data_q[head] : '0;
    assign sb_empty        = ~head_vld;

    always_comb begin
        word_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            word_match[i] = valid[i] & (word_q[i] == ld_word);
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [DEPTH-1:0]      hit;
        logic [DEPTH-1:0][7:0] lane_bytes;

        always_comb begin
            hit        = '0;
            lane_bytes = '0;
            for (int i = 0; i < DEPTH; i++) begin
                hit[i]        = word_match[i] & wen_q[i][b];
                lane_bytes[i] = data_q[i][8*b +: 8];
            end
        end

        sb_lane_select #(
            .DEPTH (DEPTH),
            .PTR_W (PTR_W)
        ) u_sel (
            .hit        (hit),
            .lane_bytes (lane_bytes),
            .head       (head),
            .found      (lane_found[b]),
            .sel        (lane_byte[b])
        );

        assign ld_fwd_data[8*b +: 8] = ld_fwd_mask[b] ? lane_byte[b] : 8'h00;
    end

    assign ld_fwd_mask = lane_found & ld_ben;
    assign ld_fwd_hit  = ld_valid & (ld_fwd_mask == ld_ben) & (ld_ben != 4'b0000);

    assign stall.store       = st_valid & ~st_ready;
    assign stall.ld_conflict = ld_valid & (ld_fwd_mask != 4'b0000) & (ld_fwd_mask != ld_ben);

    assign stallreq_for_store       = stall.store;
    assign stallreq_for_ld_conflict = stall.ld_conflict;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the buffered stores.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [3:0]  st_wen;
    logic [31:0] st_wdata;
    logic        st_ready;
    logic        stallreq_for_store;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_ben;
    logic        ld_fwd_hit;
    logic [31:0] ld_fwd_data;
    logic [3:0]  ld_fwd_mask;
    logic        stallreq_for_ld_conflict;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_ready;
    logic        sb_empty;

    store_buffer dut (
        .clk                      (clk),
        .resetn                   (resetn),
        .st_valid                 (st_valid),
        .st_addr                  (st_addr),
        .st_wen                   (st_wen),
        .st_wdata                 (st_wdata),
        .st_ready                 (st_ready),
        .stallreq_for_store       (stallreq_for_store),
        .ld_valid                 (ld_valid),
        .ld_addr                  (ld_addr),
        .ld_ben                   (ld_ben),
        .ld_fwd_hit               (ld_fwd_hit),
        .ld_fwd_data              (ld_fwd_data),
        .ld_fwd_mask              (ld_fwd_mask),
        .stallreq_for_ld_conflict (stallreq_for_ld_conflict),
        .data_sram_en             (data_sram_en),
        .data_sram_wen            (data_sram_wen),
        .data_sram_addr           (data_sram_addr),
        .data_sram_wdata          (data_sram_wdata),
        .data_sram_ready          (data_sram_ready),
        .sb_empty                 (sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] word;
        logic [3:0]  wen;
        logic [31:0] data;
    } ment_t;

    ment_t q[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_merge();
        int cnt = q.size();
        logic youngest_is_head = (cnt == 1);
        if (!st_valid || cnt < 1) return 1'b0;
        return (q[cnt-1].word == st_addr[31:2]) && !youngest_is_head;
    endfunction

    task automatic check_outputs();
        int          cnt = q.size();
        logic        retire = (cnt != 0) && data_sram_ready;
        logic        mrg = model_merge();
        logic        rdy = mrg || (cnt < 4) || retire;
        logic [3:0]  mask = '0;
        logic [31:0] fd = '0;
        for (int b = 0; b < 4; b++) begin
            logic fnd = 1'b0;
            for (int i = cnt - 1; i >= 0; i--) begin
                if (!fnd && q[i].word == ld_addr[31:2] && q[i].wen[b]) begin
                    fnd = 1'b1;
                    if (ld_ben[b]) begin
                        mask[b] = 1'b1;
                        fd[8*b +: 8] = q[i].data[8*b +: 8];
                    end
                end
            end
        end
        chk("sb_empty", sb_empty, cnt == 0);
        chk("sram_en", data_sram_en, cnt != 0);
        chk("sram_wen", data_sram_wen, cnt != 0 ? q[0].wen : 4'h0);
        chk("sram_addr", data_sram_addr, cnt != 0 ? {q[0].word, 2'b00} : 32'h0);
        chk("sram_wdata", data_sram_wdata, cnt != 0 ? q[0].data : 32'h0);
        chk("st_ready", st_ready, rdy);
        chk("stall_store", stallreq_for_store, st_valid && !rdy);
        chk("fwd_mask", ld_fwd_mask, mask);
        chk("fwd_data", ld_fwd_data, fd);
        chk("fwd_hit", ld_fwd_hit, ld_valid && (mask == ld_ben) && (ld_ben != 0));
        chk("ld_conflict", stallreq_for_ld_conflict, ld_valid && (mask != 0) && (mask != ld_ben));
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [3:0] sw,
                         input logic [31:0] sd, input logic lv, input logic [31:0] la,
                         input logic [3:0] lb, input logic rdy);
        st_valid = sv; st_addr = sa; st_wen = sw; st_wdata = sd;
        ld_valid = lv; ld_addr = la; ld_ben = lb; data_sram_ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, rdy);
    endtask

    task automatic sample();
        @(negedge clk);
        check_outputs();
    endtask

    // Advance one edge and apply the buffer's rules to the model.
    task automatic tick();
        int   cnt = q.size();
        logic retire = (cnt != 0) && data_sram_ready;
        logic mrg = model_merge();
        logic rdy = mrg || (cnt < 4) || retire;
        @(posedge clk);
        if (!resetn) begin
            q.delete();
        end else begin
            if (mrg) begin
                for (int b = 0; b < 4; b++) begin
                    if (st_wen[b]) q[cnt-1].data[8*b +: 8] = st_wdata[8*b +: 8];
                end
                q[cnt-1].wen = q[cnt-1].wen | st_wen;
            end
            if (retire) void'(q.pop_front());
            if (st_valid && rdy && !mrg) begin
                ment_t e;
                e.word = st_addr[31:2];
                e.wen  = st_wen;
                e.data = st_wdata;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        idle(1'b0);
        tick();
        tick();
        resetn = 1'b1;

        // Reset then idle
        idle(1'b0);
        sample();
        chk("rst_empty", sb_empty, 1'b1);
        chk("rst_en", data_sram_en, 1'b0);
        chk("rst_ready", st_ready, 1'b1);
        chk("rst_hit", ld_fwd_hit, 1'b0);
        tick();

        // Single store drains in one cycle
        drive(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 4'h0, 1'b1);
        step();
        idle(1'b1);
        sample();
        chk("drain_en", data_sram_en, 1'b1);
        chk("drain_addr", data_sram_addr, 32'h1000);
        chk("drain_data", data_sram_wdata, 32'hDEADBEEF);
        tick();
        sample();
        chk("drain_empty", sb_empty, 1'b1);
        tick();

        // Fill under backpressure, 5th store blocked then accepted on retire
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1100 + 32'(4*i), 4'hF, 32'hA0 + 32'(i), 1'b0, 32'h0, 4'h0, 1'b0);
            step();
        end
        drive(1'b1, 32'h1110, 4'hF, 32'hA4, 1'b0, 32'h0, 4'h0, 1'b0);
        sample();
        chk("full_ready", st_ready, 1'b0);
        chk("full_stall", stallreq_for_store, 1'b1);
        tick();
        data_sram_ready = 1'b1;
        sample();
        chk("full_retire_ready", st_ready, 1'b1);
        tick();
        idle(1'b1);
        for (int i = 0; i < 5; i++) step();

        // Coalescing into the youngest entry
        drive(1'b1, 32'h2000, 4'h1, 32'h00000011, 1'b0, 32'h0, 4'h0, 1'b0);
        step();
        drive(1'b1, 32'h2004, 4'h1, 32'h00000033, 1'b0, 32'h0, 4'h0, 1'b0);
        step();
        drive(1'b1, 32'h2004, 4'h2, 32'h00002200, 1'b0, 32'h0, 4'h0, 1'b0);
        step();
        chk("merge_count", q.size(), 2);
        idle(1'b1);
        sample();
        chk("merge_head_addr", data_sram_addr, 32'h2000);
        tick();
        sample();
        chk("merge_wen", data_sram_wen, 4'h3);
        chk("merge_data", data_sram_wdata, 32'h00002233);
        tick();
        step();

        // Forwarding and partial-overlap conflict
        drive(1'b1, 32'h3000, 4'h3, 32'h0000AABB, 1'b0, 32'h0, 4'h0, 1'b0);
        step();
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h3000, 4'h3, 1'b0);
        sample();
        chk("fwd_full_hit", ld_fwd_hit, 1'b1);
        chk("fwd_full_data", ld_fwd_data, 32'h0000AABB);
        tick();
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h3000, 4'hF, 1'b1);
        sample();
        chk("fwd_part_conflict", stallreq_for_ld_conflict, 1'b1);
        chk("fwd_part_hit", ld_fwd_hit, 1'b0);
        tick();
        sample();
        chk("fwd_drained_conflict", stallreq_for_ld_conflict, 1'b0);
        tick();

        // Youngest entry wins per lane
        drive(1'b1, 32'h4000, 4'hF, 32'h11111111, 1'b0, 32'h0, 4'h0, 1'b0);
        step();
        drive(1'b1, 32'h4000, 4'h1, 32'h00000022, 1'b0, 32'h0, 4'h0, 1'b0);
        step();
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h4000, 4'hF, 1'b0);
        sample();
        chk("young_data", ld_fwd_data, 32'h11111122);
        chk("young_hit", ld_fwd_hit, 1'b1);
        tick();

        // Reset while draining drops the entry
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        idle(1'b0);
        sample();
        chk("rst_mid_en", data_sram_en, 1'b0);
        tick();

        // Random traffic over a small word pool to exercise merges and wrap
        for (int n = 0; n < 3000; n++) begin
            logic rdy;
            rdy = (n < 1500) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
            drive(1'($urandom), 32'h5000 + 32'(4 * ($urandom % 4)) + 32'($urandom % 4),
                  4'($urandom), $urandom,
                  1'($urandom), 32'h5000 + 32'(4 * ($urandom % 4)) + 32'($urandom % 4),
                  4'($urandom), rdy);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
